// File: rtl/prog_loader_if.sv
// Interface bundle for prog_loader: the load request, the byte stream,
// and the fetch path toward cpu_core.
//
// Signals:
//   load_start/load_base/load_len - load request (master -> slave)
//   in_valid/in_data/in_ready     - byte stream, MSB-first per word
//   progctr/opcode                - fetch address in, instruction out
//   core_rst_n/busy/done          - core reset and loader status
//   words_loaded                  - words written by current/last load
interface prog_loader_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 8,
    parameter int BYTE_WIDTH  = 8
);
    logic                   load_start;
    logic [PC_WIDTH-1:0]    load_base;
    logic [PC_WIDTH-1:0]    load_len;
    logic                   in_valid;
    logic [BYTE_WIDTH-1:0]  in_data;
    logic                   in_ready;
    logic [PC_WIDTH-1:0]    progctr;
    logic [INSTR_WIDTH-1:0] opcode;
    logic                   core_rst_n;
    logic                   busy;
    logic                   done;
    logic [PC_WIDTH-1:0]    words_loaded;

    modport master (
        output load_start, load_base, load_len,
        output in_valid, in_data, progctr,
        input  in_ready, opcode, core_rst_n,
        input  busy, done, words_loaded
    );

    modport slave (
        input  load_start, load_base, load_len,
        input  in_valid, in_data, progctr,
        output in_ready, opcode, core_rst_n,
        output busy, done, words_loaded
    );
endinterface

// File: rtl/prog_loader.sv
// Program memory for cpu_core plus a byte-stream loader that writes a
// block of words at a base address while holding the core in reset.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - prog_loader_if.slave (load request, byte stream, fetch path,
//         core_rst_n, busy, done, words_loaded)
module prog_loader #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 8,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    localparam int BPW   = INSTR_WIDTH / BYTE_WIDTH;
    localparam int CW    = $clog2(BPW + 1);
    localparam int DEPTH = 1 << PC_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [PC_WIDTH-1:0]    len_q, len_d;
    logic [PC_WIDTH-1:0]    wcnt_q, wcnt_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [INSTR_WIDTH-1:0] word_q, word_d;
    logic                   crst_n_q, crst_n_d;
    logic                   accept;
    logic [PC_WIDTH-1:0]    wcnt_inc;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    assign accept   = bus.in_valid && (state_q == RECV);
    assign wcnt_inc = wcnt_q + PC_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    addr_d  = bus.load_base;
                    len_d   = bus.load_len;
                    wcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = (bus.load_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    // First byte of a word ends up in the MSBs.
                    word_d = (word_q << BYTE_WIDTH)
                           | INSTR_WIDTH'(bus.in_data);
                    if (bcnt_q == CW'(BPW - 1)) begin
                        bcnt_d  = '0;
                        state_d = WRITE;
                    end else begin
                        bcnt_d = bcnt_q + CW'(1);
                    end
                end
            end
            WRITE: begin
                addr_d  = addr_q + PC_WIDTH'(1);
                wcnt_d  = wcnt_inc;
                bcnt_d  = '0;
                state_d = (wcnt_inc == len_q) ? DONE : RECV;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Core runs only while the loader sits in IDLE.
        crst_n_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            crst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            crst_n_q <= crst_n_d;
        end
    end

    // Storage is deliberately not reset; an async rst drops state_q out
    // of WRITE immediately, so no write happens during reset.
    always_ff @(posedge clk) begin
        if (state_q == WRITE) begin
            mem[addr_q] <= word_q;
        end
    end

    assign bus.in_ready     = (state_q == RECV);
    assign bus.busy         = (state_q == RECV) || (state_q == WRITE);
    assign bus.done         = (state_q == DONE);
    assign bus.words_loaded = wcnt_q;
    assign bus.core_rst_n   = crst_n_q;
    // Noop whenever the core is held in reset, so writes never race a fetch.
    assign bus.opcode       = crst_n_q ? mem[bus.progctr] : '0;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, streamed loads, stalls,
// address wrap, empty load and reset in the middle of a load.
module tb_prog_loader;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [7:0] stream [16];
    int         cyc;
    logic [15:0] pat;
    int         idx;
    bit         ok;

    prog_loader_if #(.INSTR_WIDTH(32), .PC_WIDTH(8), .BYTE_WIDTH(8)) ifc ();

    prog_loader #(
        .INSTR_WIDTH(32),
        .PC_WIDTH(8),
        .BYTE_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) begin
                stream[i*4+b] = w[i][31-8*b -: 8];
            end
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a,
                      input logic [31:0] exp);
        ifc.progctr = a;
        #1;
        chk(tag, ifc.opcode, exp);
    endtask

    // Pulse load_start, feed nb bytes; returns at the negedge of the
    // DONE cycle. cyc counts cycles after the start edge.
    task automatic run_load(input logic [7:0] base, input logic [7:0] len,
                            input int nb, input bit gap,
                            output int c_out, output logic [15:0] p_out);
        int k;
        k = 0;
        c_out = 0;
        p_out = '0;
        ifc.load_base  = base;
        ifc.load_len   = len;
        ifc.load_start = 1'b1;
        @(negedge clk);
        ifc.load_start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c <= 15) p_out = {p_out[14:0], ifc.in_ready};
            if (ifc.done) begin
                c_out = c;
                break;
            end
            ifc.in_valid = (k < nb) && (!gap || (c % 2 == 1));
            ifc.in_data  = (k < 16) ? stream[k] : 8'h00;
            if (ifc.in_valid && ifc.in_ready) k++;
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        if (c_out == 0) chk("load_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ifc.load_start = 1'b0;
        ifc.load_base  = '0;
        ifc.load_len   = '0;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = '0;
        ifc.progctr    = '0;

        // 1: reset
        repeat (3) @(negedge clk);
        chk("rst_core_rst_n", ifc.core_rst_n, 0);
        chk("rst_opcode", ifc.opcode, 0);
        chk("rst_in_ready", ifc.in_ready, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_words", ifc.words_loaded, 0);
        rst = 1'b0;
        #1;
        chk("rel_before_edge", ifc.core_rst_n, 0);
        @(negedge clk);
        chk("rel_after_edge", ifc.core_rst_n, 1);

        // 2: three words, in_valid held high
        set_words(32'h8C06_0049, 32'h8C0A_004A, 32'h1A98_0000, 32'h0);
        run_load(8'h00, 8'd3, 12, 1'b0, cyc, pat);
        chk("t2_cycles", cyc, 16);
        chk("t2_ready_pat", pat, 16'h7BDE);
        chk("t2_done", ifc.done, 1);
        chk("t2_busy_done", ifc.busy, 0);
        chk("t2_words", ifc.words_loaded, 3);
        chk("t2_core_rst_in_done", ifc.core_rst_n, 0);
        chk("t2_opcode_in_done", ifc.opcode, 0);
        @(negedge clk);
        chk("t2_done_gone", ifc.done, 0);
        chk("t2_core_rel", ifc.core_rst_n, 1);
        rd("t2_mem0", 8'h00, 32'h8C06_0049);
        rd("t2_mem1", 8'h01, 32'h8C0A_004A);
        rd("t2_mem2", 8'h02, 32'h1A98_0000);

        // 3: same words at 0x20, valid every other cycle
        @(negedge clk);
        run_load(8'h20, 8'd3, 12, 1'b1, cyc, pat);
        chk("t3_cycles", cyc, 25);
        chk("t3_words", ifc.words_loaded, 3);
        @(negedge clk);
        rd("t3_mem20", 8'h20, 32'h8C06_0049);
        rd("t3_mem21", 8'h21, 32'h8C0A_004A);
        rd("t3_mem22", 8'h22, 32'h1A98_0000);

        // 4: address wrap
        set_words(32'h1122_3344, 32'h5566_7788,
                  32'h99AA_BBCC, 32'hDDEE_FF00);
        @(negedge clk);
        run_load(8'hFE, 8'd4, 16, 1'b0, cyc, pat);
        chk("t4_cycles", cyc, 21);
        chk("t4_words", ifc.words_loaded, 4);
        @(negedge clk);
        rd("t4_memFE", 8'hFE, 32'h1122_3344);
        rd("t4_memFF", 8'hFF, 32'h5566_7788);
        rd("t4_mem00", 8'h00, 32'h99AA_BBCC);
        rd("t4_mem01", 8'h01, 32'hDDEE_FF00);
        rd("t4_mem02", 8'h02, 32'h1A98_0000);

        // 5: zero-length load
        @(negedge clk);
        run_load(8'h00, 8'd0, 0, 1'b0, cyc, pat);
        chk("t5_cycles", cyc, 1);
        chk("t5_no_ready", pat, 16'h0000);
        chk("t5_core_low", ifc.core_rst_n, 0);
        chk("t5_words", ifc.words_loaded, 0);
        @(negedge clk);
        chk("t5_core_high", ifc.core_rst_n, 1);
        rd("t5_mem00", 8'h00, 32'h99AA_BBCC);
        rd("t5_mem01", 8'h01, 32'hDDEE_FF00);

        // 6: rst after 6 bytes of a 2-word load; stray load_start ignored
        set_words(32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'h0, 32'h0);
        @(negedge clk);
        ifc.load_base  = 8'h00;
        ifc.load_len   = 8'd2;
        ifc.load_start = 1'b1;
        @(negedge clk);
        ifc.load_start = 1'b0;
        idx = 0;
        ok  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 3) begin
                ifc.load_start = 1'b1;
                ifc.load_base  = 8'h80;
                ifc.load_len   = 8'd1;
            end else begin
                ifc.load_start = 1'b0;
            end
            if (idx == 6) begin
                ok = 1'b1;
                break;
            end
            ifc.in_valid = 1'b1;
            ifc.in_data  = stream[idx];
            if (ifc.in_ready) idx++;
            @(negedge clk);
        end
        ifc.in_valid   = 1'b0;
        ifc.load_start = 1'b0;
        chk("t6_reached", ok, 1);
        chk("t6_words_mid", ifc.words_loaded, 1);
        chk("t6_busy_mid", ifc.busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", ifc.in_ready, 0);
        chk("t6_rst_busy", ifc.busy, 0);
        chk("t6_rst_words", ifc.words_loaded, 0);
        chk("t6_rst_core", ifc.core_rst_n, 0);
        chk("t6_rst_opcode", ifc.opcode, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_core_rel", ifc.core_rst_n, 1);
        chk("t6_idle_busy", ifc.busy, 0);
        chk("t6_idle_ready", ifc.in_ready, 0);
        rd("t6_mem00", 8'h00, 32'hA0A1_A2A3);
        rd("t6_mem01", 8'h01, 32'hDDEE_FF00);
        rd("t6_memFE", 8'hFE, 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Program-memory stage directly upstream of cpu_core.
- Holds INSTR_WIDTH-wide instructions, indexed by the core's progctr; drives the core's opcode input combinationally.
- Also contains a byte-stream loader FSM. It writes a block of instructions at a base address and holds the core in reset while loading.
- Replaces the bench-side progmem array with synthesizable storage.

Parameters:
INSTR_WIDTH, 32, instruction width; must be a multiple of BYTE_WIDTH
PC_WIDTH, 8, program counter width; memory depth is 2**PC_WIDTH words
BYTE_WIDTH, 8, width of one load-stream beat

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
load_start  input  1  one-cycle request to begin a load; sampled only in IDLE
load_base  input  PC_WIDTH  first word address; captured with load_start
load_len  input  PC_WIDTH  number of words to load; 0 means no words; captured with load_start
in_valid  input  1  stream byte valid
in_data  input  BYTE_WIDTH  stream byte, most significant byte of each word first
in_ready  output  1  loader accepts a byte this cycle
progctr  input  PC_WIDTH  fetch address from cpu_core
opcode  output  INSTR_WIDTH  instruction to cpu_core
core_rst_n  output  1  active-low reset for cpu_core, registered
busy  output  1  load in progress
done  output  1  one-cycle pulse when a load completes
words_loaded  output  PC_WIDTH  words written by the current or last load

Behaviour:
- Reset values:
  - FSM = IDLE.
  - in_ready = 0, busy = 0, done = 0, words_loaded = 0.
  - core_rst_n = 0. It rises on the first clock edge after rst deasserts.
  - Byte counter and assembly register cleared.
  - Memory array is not reset.
- Byte counting: BPW = INSTR_WIDTH/BYTE_WIDTH (4 at defaults). A byte is accepted when in_valid and in_ready are both high at a clock edge.
- States:
  - IDLE:
    - in_ready = 0; core_rst_n = 1.
    - On load_start: capture base and len; clear words_loaded and the byte counter.
    - If len == 0, go to DONE; else go to RECV.
  - RECV:
    - in_ready = 1; busy = 1; core_rst_n = 0.
    - Each accepted byte shifts into the assembly register from the LSB side: word <= {word, in_data}, so the first byte ends up in the MSBs.
    - When the BPWth byte is accepted, go to WRITE.
    - in_valid low: stall indefinitely; no timeout.
  - WRITE:
    - One cycle; in_ready = 0.
    - mem[addr] <= word; addr <= addr+1, wrapping mod 2**PC_WIDTH; words_loaded <= words_loaded+1.
    - If the new words_loaded == len, go to DONE; else go back to RECV with the byte counter cleared.
  - DONE:
    - One cycle; done = 1; busy = 0; in_ready = 0.
    - Next state IDLE. core_rst_n returns to 1 on the edge leaving DONE, i.e. the core sees reset released one cycle after the done pulse.
- core_rst_n is registered: 1 exactly when the next state is IDLE and rst is low.
- Throughput: one word per BPW+1 cycles with in_valid held high (4 byte cycles + 1 write cycle).
- opcode:
  - Combinational: mem[progctr] when core_rst_n = 1; all-zero (noop) otherwise.
  - Zero is forced whenever core_rst_n is low, including during rst and loading.
- load_start while not in IDLE is ignored.
- Address wrap: base = 0xFE with len = 4 writes 0xFE, 0xFF, 0x00, 0x01.
- rst mid-load:
  - Immediate return to IDLE.
  - Partially assembled word discarded.
  - Words already written remain in memory; words_loaded cleared.
- Memory has no read-during-write hazard visible to the core, because the core is held in reset during any write.

Test Plan:
1. rst high 3 cycles then low -> core_rst_n=0 during rst, 1 one edge after release; opcode=0 while rst is high.
2. load_start base=0x00 len=3; bytes 8C,06,00,49 / 8C,0A,00,4A / 1A,98,00,00 with in_valid held high -> in_ready pattern 1111 0 1111 0 1111 0; done pulses at cycle 16 after start; words_loaded=3; afterwards progctr=1 gives opcode=0x8C0A004A.
3. Same load with in_valid toggling every other cycle -> identical memory contents; completion takes 24+ cycles; no byte lost or duplicated.
4. base=0xFE len=4 -> words land at 0xFE, 0xFF, 0x00, 0x01; progctr=0x00 returns the third word.
5. len=0 -> no in_ready; done one cycle after start; memory unchanged; core_rst_n low for exactly one cycle.
6. Assert rst after 6 bytes of a len=2 load -> word 0 written, word 1 absent; FSM idle; load_start during the prior busy period had no effect.
